ahb_uart_tx: RTL and testbench
==============================

Name: ahb_uart_tx

Overview:
AHB-Lite slave peripheral on the Cortex-M0 bus, selected by the system decoder next to the ROM. Firmware writes bytes into a small transmit FIFO. A serializer emits them as 8N1 UART frames on o_uart_tx. It gives the CPU a visible console output alongside the TXEV-driven LED, with a status register and an optional "transmit done" interrupt.

Parameters:
FIFO_DEPTH, 8, transmit FIFO entries; power of 2, minimum 2.
BAUDDIV_RESET, 16'd12, reset value of BAUDDIV; bit period = BAUDDIV+1 clocks.

Ports:
i_clk  input  1  system clock, the same clock as the core's HCLK.
i_reset  input  1  asynchronous, active-high reset.
HSEL  input  1  slave select from the decoder.
HADDR  input  32  address; only HADDR[3:2] decoded.
HTRANS  input  2  transfer type; HTRANS[1]=1 means active.
HWRITE  input  1  write control.
HSIZE  input  3  size; ignored, all accesses treated as word.
HWDATA  input  32  write data, sampled in data phase.
HREADY  input  1  bus ready.
HRDATA  output  32  read data.
HREADYOUT  output  1  always 1 (zero wait states).
HRESP  output  1  always 0 (OKAY).
o_uart_tx  output  1  serial output, idle high.
o_irq  output  1  level interrupt.

Behaviour:
- Reset values: o_uart_tx=1, o_irq=0, HRDATA=0, FIFO empty, CTRL=0, BAUDDIV=BAUDDIV_RESET, OVF=0, FSM=IDLE.
- AHB address phase is accepted when HSEL & HREADY & HTRANS[1]. On acceptance, register HADDR[3:2], HWRITE and a valid flag. Write data (HWDATA) is applied in the following data-phase cycle.
- Read data: HRDATA is combinational from the registered address during the data phase, and 0 otherwise.
- Register map:
  - 0x0 DATA (W): push HWDATA[7:0] into the FIFO; reads return 0.
  - 0x4 STATUS: bit0 BUSY (FSM != IDLE), bit1 FULL, bit2 EMPTY, bit3 OVF, bits[7:4] FIFO level (saturating at 15). Writing 1 to bit3 clears OVF.
  - 0x8 BAUDDIV (RW): bits[15:0].
  - 0xC CTRL (RW): bit0 EN, bit1 IRQEN.
- FIFO push/pop rules:
  - A push is accepted if not full, or if a pop occurs in the same cycle.
  - A push that is not accepted is dropped and sets OVF.
  - The level is visible in STATUS the cycle after the push.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if EN & !EMPTY, pop the byte into the shift register, latch BAUDDIV into the frame divisor, go to START. o_uart_tx falls on the next clock.
  - START: drive 0 for one bit period.
  - DATA: drive 8 bits, LSB first, one bit period each; a bit counter 0..7.
  - STOP: drive 1 for one bit period. On its last cycle, if EN & !EMPTY, pop and go directly to START (no idle gap); otherwise go to IDLE.
  - Bit timing comes from a down-counter reloaded with the latched divisor.
- Frame length is 10*(div+1) clocks. BAUDDIV=0 gives 1 clock per bit.
- A BAUDDIV write mid-frame takes effect from the next frame.
- Clearing EN mid-frame: the current frame completes and no further pops occur; the FIFO contents are retained.
- o_irq = IRQEN & EMPTY & (FSM==IDLE), registered (one-cycle delay).
- Latency: a DATA write data phase in cycle N means o_uart_tx is low from cycle N+2, given IDLE and EN=1.
- Reset asserted mid-frame: o_uart_tx goes high immediately, and the FIFO and FSM are cleared.

Decomposition:
- Shared package ahb_uart_pkg: register offsets (DATA/STATUS/BAUDDIV/CTRL), STATUS/CTRL bit indices, FSM state enum.
- One sub-module, sync_fifo (parameterised WIDTH/DEPTH, with full/empty/level outputs), instantiated with WIDTH=8.

Test Plan:
1. Reset, then read all registers -> STATUS=0x04, BAUDDIV=12, CTRL=0, o_uart_tx=1, HREADYOUT=1, HRESP=0.
2. CTRL=1, BAUDDIV=3, write DATA=0xA5 -> o_uart_tx low 2 cycles after the data phase; bit sequence 0,1,0,1,0,0,1,0,1,1 at 4 clocks each; 40-clock frame.
3. Write 3 bytes back-to-back with EN=1 -> three contiguous frames with no idle cycles; BUSY=1 throughout; EMPTY and !BUSY only after the final stop bit.
4. EN=0, write 9 bytes (FIFO_DEPTH=8) -> level 8, FULL=1, OVF=1; write STATUS=0x8 -> OVF=0; set EN -> exactly 8 frames transmitted.
5. IRQEN=1, EN=1, send one byte -> o_irq=0 during the frame, 1 one cycle after return to IDLE; clearing IRQEN drops it next cycle.
6. Assert i_reset mid DATA bit -> o_uart_tx=1 asynchronously; after release STATUS=0x04 and no residual transmission.

Source files
------------

// File: rtl/ahb_uart_pkg.sv
// ---------------------------------------------------------------
// ahb_uart_pkg : register map, bit indices and FSM states for ahb_uart_tx
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package ahb_uart_pkg;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  localparam int ST_BUSY      = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_EMPTY     = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_LEVEL_LSB = 4;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_IRQEN = 1;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------
// sync_fifo : single-clock FIFO with full/empty/level and fall-through read
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // A simultaneous pop frees a slot, so a push into a full FIFO still lands
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);
  assign level = count;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/ahb_uart_tx.sv
// ---------------------------------------------------------------
// ahb_uart_tx : AHB-Lite slave feeding a TX FIFO into an 8N1 serializer
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module ahb_uart_tx
  import ahb_uart_pkg::*;
#(
  parameter int          FIFO_DEPTH    = 8,
  parameter logic [15:0] BAUDDIV_RESET = 16'd12
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic        o_uart_tx,
  output logic        o_irq
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          dp_valid, dp_write;
  logic [1:0]    dp_addr;
  logic [1:0]    ctrl;
  logic [15:0]   baud;
  logic          ovf;
  tx_state_t     state, state_nxt;
  logic [7:0]    shreg;
  logic [15:0]   div_lat, cnt;
  logic [2:0]    bitcnt;
  logic          irq_r;
  logic          fifo_full, fifo_empty;
  logic [LW-1:0] fifo_level;
  logic [7:0]    fifo_dout;
  logic          wr_en, push, pop, bit_end;
  logic [31:0]   level_ext;
  logic [3:0]    level_sat;
  logic [31:0]   status;
  logic          unused;

  assign unused    = ^{HSIZE, HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:16], level_ext[31:4]};
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign o_irq     = irq_r;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= 2'd0;
    end else begin
      dp_valid <= HSEL & HREADY & HTRANS[1];
      if (HSEL & HREADY & HTRANS[1]) begin
        dp_addr  <= HADDR[3:2];
        dp_write <= HWRITE;
      end
    end
  end

  assign wr_en = dp_valid & dp_write;
  assign push  = wr_en & (dp_addr == REG_DATA);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ctrl <= 2'd0;
      baud <= BAUDDIV_RESET;
      ovf  <= 1'b0;
    end else begin
      if (wr_en && dp_addr == REG_CTRL)    ctrl <= HWDATA[1:0];
      if (wr_en && dp_addr == REG_BAUDDIV) baud <= HWDATA[15:0];
      if (push && fifo_full && !pop)
        ovf <= 1'b1;
      else if (wr_en && dp_addr == REG_STATUS && HWDATA[ST_OVF])
        ovf <= 1'b0;
    end
  end

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (i_clk),
    .rst   (i_reset),
    .push  (push),
    .pop   (pop),
    .din   (HWDATA[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign level_ext = 32'(fifo_level);
  assign level_sat = (level_ext > 32'd15) ? 4'hF : level_ext[3:0];

  always_comb begin
    status                          = '0;
    status[ST_BUSY]                 = (state != TX_IDLE);
    status[ST_FULL]                 = fifo_full;
    status[ST_EMPTY]                = fifo_empty;
    status[ST_OVF]                  = ovf;
    status[ST_LEVEL_LSB +: 4]       = level_sat;
  end

  always_comb begin
    HRDATA = '0;
    if (dp_valid && !dp_write) begin
      case (dp_addr)
        REG_STATUS:  HRDATA = status;
        REG_BAUDDIV: HRDATA = {16'd0, baud};
        REG_CTRL:    HRDATA = {30'd0, ctrl};
        default:     HRDATA = '0;
      endcase
    end
  end

  assign bit_end = (cnt == 16'd0);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= TX_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      TX_IDLE:
        if (ctrl[CTRL_EN] && !fifo_empty) begin
          pop       = 1'b1;
          state_nxt = TX_START;
        end
      TX_START:
        if (bit_end) state_nxt = TX_DATA;
      TX_DATA:
        if (bit_end && bitcnt == 3'd7) state_nxt = TX_STOP;
      TX_STOP:
        if (bit_end) begin
          // Chain straight into the next frame so queued bytes leave gap-free
          if (ctrl[CTRL_EN] && !fifo_empty) begin
            pop       = 1'b1;
            state_nxt = TX_START;
          end else begin
            state_nxt = TX_IDLE;
          end
        end
      default: state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      shreg   <= 8'd0;
      div_lat <= 16'd0;
      cnt     <= 16'd0;
      bitcnt  <= 3'd0;
      irq_r   <= 1'b0;
    end else begin
      irq_r <= ctrl[CTRL_IRQEN] & fifo_empty & (state == TX_IDLE);
      if (pop) begin
        shreg   <= fifo_dout;
        div_lat <= baud;
        cnt     <= baud;
      end else if (state != TX_IDLE) begin
        if (bit_end) begin
          cnt <= div_lat;
          if (state == TX_START) bitcnt <= 3'd0;
          if (state == TX_DATA) begin
            shreg  <= shreg >> 1;
            bitcnt <= bitcnt + 3'd1;
          end
        end else begin
          cnt <= cnt - 16'd1;
        end
      end
    end
  end

  assign o_uart_tx = (state == TX_START) ? 1'b0 :
                     (state == TX_DATA)  ? shreg[0] : 1'b1;

endmodule

`default_nettype wire

// File: tb/tb_ahb_uart_tx.sv
// ---------------------------------------------------------------
// tb_ahb_uart_tx : scoreboard bench decoding UART frames against expected bytes
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_ahb_uart_tx;

  localparam int FIFO_DEPTH = 8;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        HSEL, HWRITE, HREADY;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [31:0] HRDATA;
  logic        HREADYOUT, HRESP, o_uart_tx, o_irq;

  ahb_uart_tx #(.FIFO_DEPTH(FIFO_DEPTH), .BAUDDIV_RESET(16'd12)) dut (
    .i_clk(clk), .i_reset(i_reset), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .o_uart_tx(o_uart_tx), .o_irq(o_irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    int         div;
    int         start_at;
    bit         contig;
  } exp_t;

  exp_t sb[$];
  int compared = 0, mismatched = 0;
  int cur_div = 12, wr_cyc = 0;
  int frames_started = 0, frames_done = 0, last_end_cyc = -100;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic ahb_write(input logic [3:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {28'd0, addr};
    @(posedge clk); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = data; wr_cyc = cyc;
    @(posedge clk);
  endtask

  task automatic ahb_read(input logic [3:0] addr, output logic [31:0] data);
    @(posedge clk); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {28'd0, addr};
    @(posedge clk); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    @(negedge clk);
    data = HRDATA;
  endtask

  task automatic chk_reg(input string name, input logic [3:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    ahb_read(addr, d);
    chk(name, d, exp);
  endtask

  task automatic set_baud(input int d);
    ahb_write(4'h8, 32'(d));
    cur_div = d;
  endtask

  // Expected start cycle: written in data phase N, line drops in cycle N+2
  task automatic send_byte(input logic [7:0] b, input bit contig, input bit lat);
    exp_t e;
    ahb_write(4'h0, {24'd0, b});
    e.data = b; e.div = cur_div; e.contig = contig;
    e.start_at = lat ? wr_cyc + 2 : -1;
    sb.push_back(e);
  endtask

  task automatic wait_frames(input int k, input int budget);
    int n = 0;
    while (frames_done < k && n < budget) begin @(negedge clk); n++; end
    chk("frames_done", frames_done, k);
  endtask

  task automatic wait_started(input int k, input int budget);
    int n = 0;
    while (frames_started < k && n < budget) begin @(negedge clk); n++; end
    chk("frames_started", frames_started, k);
  endtask

  initial begin : monitor
    logic       prev;
    logic [9:0] bits;
    bit         glitch, abort;
    int         d, st;
    exp_t       e;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!i_reset && prev && (o_uart_tx === 1'b0)) begin
        st = cyc;
        frames_started++;
        d = (sb.size() > 0) ? sb[0].div : cur_div;
        bits = '0; glitch = 0; abort = 0;
        for (int b = 0; b < 10; b++) begin
          for (int c = 0; c <= d; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (i_reset) abort = 1;
            if (c == 0) bits[b] = o_uart_tx;
            else if (o_uart_tx !== bits[b]) glitch = 1;
          end
        end
        if (!abort) begin
          if (sb.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL unexpected_frame: got frame 0x%0h expected none", bits);
          end else begin
            e = sb.pop_front();
            chk("frame_bits", {21'd0, glitch, bits}, {21'd0, 1'b0, 1'b1, e.data, 1'b0});
            if (e.contig) chk("frame_gap", 32'(st - last_end_cyc - 1), 32'd0);
            if (e.start_at >= 0) chk("start_latency", 32'(st), 32'(e.start_at));
          end
        end
        last_end_cyc = cyc;
        frames_done++;
      end
      prev = o_uart_tx;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [31:0] rd;
    logic [7:0]  b;
    exp_t        e;
    int          base, bdone, n;
    HSEL = 0; HWRITE = 0; HREADY = 1; HADDR = 0; HWDATA = 0; HTRANS = 0; HSIZE = 3'b010;
    i_reset = 1'b1;
    repeat (3) @(negedge clk);
    i_reset = 1'b0;

    @(negedge clk);
    chk("rst_tx", {31'd0, o_uart_tx}, 32'd1);
    chk("rst_irq", {31'd0, o_irq}, 32'd0);
    chk("hreadyout", {31'd0, HREADYOUT}, 32'd1);
    chk("hresp", {31'd0, HRESP}, 32'd0);
    chk("rst_hrdata", HRDATA, 32'd0);
    chk_reg("rst_status", 4'h4, 32'h04);
    chk_reg("rst_baud", 4'h8, 32'd12);
    chk_reg("rst_ctrl", 4'hC, 32'd0);
    chk_reg("data_read", 4'h0, 32'd0);

    set_baud(3);
    chk_reg("baud_rb", 4'h8, 32'd3);
    ahb_write(4'hC, 32'd1);
    chk_reg("ctrl_rb", 4'hC, 32'd1);
    send_byte(8'hA5, 1'b0, 1'b1);
    wait_frames(1, 200);

    base = frames_done;
    send_byte(8'($urandom), 1'b0, 1'b0);
    send_byte(8'($urandom), 1'b1, 1'b0);
    send_byte(8'($urandom), 1'b1, 1'b0);
    repeat (5) begin
      repeat (10) @(negedge clk);
      ahb_read(4'h4, rd);
      chk("busy_during", {31'd0, rd[0]}, 32'd1);
    end
    wait_frames(base + 3, 400);
    chk_reg("idle_status", 4'h4, 32'h04);

    // Divisor rewritten while the first frame is on the wire
    base = frames_done;
    set_baud(2);
    send_byte(8'($urandom), 1'b0, 1'b0);
    set_baud(1);
    send_byte(8'($urandom), 1'b1, 1'b0);
    wait_frames(base + 2, 300);

    for (int i = 0; i < 6; i++) begin
      base = frames_done;
      set_baud(int'($urandom_range(0, 3)));
      send_byte(8'($urandom), 1'b0, 1'($urandom_range(0, 1)));
      wait_frames(base + 1, 200);
    end

    set_baud(3);
    ahb_write(4'hC, 32'd0);
    for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
      b = 8'($urandom);
      ahb_write(4'h0, {24'd0, b});
      if (i < FIFO_DEPTH) begin
        e.data = b; e.div = 3; e.start_at = -1; e.contig = (i > 0);
        sb.push_back(e);
      end
    end
    chk_reg("full_status", 4'h4, {24'd0, 4'(FIFO_DEPTH), 4'b1010});
    ahb_write(4'h4, 32'h8);
    chk_reg("ovf_cleared", 4'h4, {24'd0, 4'(FIFO_DEPTH), 4'b0010});
    base = frames_done;
    ahb_write(4'hC, 32'd1);
    wait_frames(base + FIFO_DEPTH, 600);
    chk_reg("drained_status", 4'h4, 32'h04);

    ahb_write(4'hC, 32'd3);
    repeat (2) @(negedge clk);
    chk("irq_idle", {31'd0, o_irq}, 32'd1);
    base = frames_started;
    bdone = frames_done;
    send_byte(8'($urandom), 1'b0, 1'b0);
    wait_started(base + 1, 50);
    repeat (10) @(negedge clk);
    chk("irq_in_frame", {31'd0, o_irq}, 32'd0);
    wait_frames(bdone + 1, 200);
    while (cyc < last_end_cyc + 1) @(negedge clk);
    chk("irq_first_idle", {31'd0, o_irq}, 32'd0);
    @(negedge clk);
    chk("irq_after_idle", {31'd0, o_irq}, 32'd1);
    ahb_write(4'hC, 32'd1);
    repeat (2) @(negedge clk);
    chk("irq_cleared", {31'd0, o_irq}, 32'd0);

    // Reset in the middle of data bit 2 of an all-zero byte
    set_baud(3);
    base = frames_started;
    ahb_write(4'h0, 32'h00);
    wait_started(base + 1, 50);
    repeat (14) @(negedge clk);
    chk("pre_reset_tx", {31'd0, o_uart_tx}, 32'd0);
    #2 i_reset = 1'b1;
    #1 chk("async_reset_tx", {31'd0, o_uart_tx}, 32'd1);
    repeat (3) @(negedge clk);
    #2 i_reset = 1'b0;
    chk_reg("post_reset_status", 4'h4, 32'h04);
    chk_reg("post_reset_baud", 4'h8, 32'd12);
    chk_reg("post_reset_ctrl", 4'hC, 32'd0);
    base = frames_started;
    repeat (100) @(negedge clk);
    chk("no_residual", 32'(frames_started), 32'(base));

    n = 0;
    while (sb.size() > 0 && n < 500) begin @(negedge clk); n++; end
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
